// File: rtl/mc_control_fsm_pkg.sv
// Shared opcode, state and datapath-select encodings for the multicycle control unit.
// MC_ILLEGAL_OPCODE_TRAP_EN adds the HALT state used by the illegal-opcode trap.
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_AND   = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUSRCB_B      = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR   = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM    = 2'b10;
  localparam logic [1:0] ALUSRCB_IMM_SH = 2'b11;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] MEMTOREG_ALU = 2'b00;
  localparam logic [1:0] MEMTOREG_MDR = 2'b01;
  localparam logic [1:0] MEMTOREG_PC  = 2'b10;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEM_ADDR = 4'd2,
    ST_MEM_RD   = 4'd3,
    ST_MEM_WB   = 4'd4,
    ST_MEM_WR   = 4'd5,
    ST_EXEC_R   = 4'd6,
    ST_R_WB     = 4'd7,
    ST_EXEC_I   = 4'd8,
    ST_I_WB     = 4'd9,
    ST_BRANCH   = 4'd10,
    ST_JUMP     = 4'd11,
    ST_JAL      = 4'd12
`ifdef MC_ILLEGAL_OPCODE_TRAP_EN
    , ST_HALT   = 4'd13
`endif
  } state_e;

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multicycle FSM (master) and the datapath (slave).
interface mc_control_fsm_if #(
  parameter int INSTR_CNT_W = 32
) ();
  logic [5:0]             opcode;
  logic                   memReady;
  logic                   pcWrite;
  logic                   pcWriteCond;
  logic                   branchNe;
  logic                   iorD;
  logic                   memRead;
  logic                   memWrite;
  logic                   irWrite;
  logic [1:0]             regDst;
  logic [1:0]             memToReg;
  logic                   regWrite;
  logic                   aluSrcA;
  logic [1:0]             aluSrcB;
  logic [1:0]             aluOp;
  logic [1:0]             pcSrc;
  logic                   instrRetired;
  logic [INSTR_CNT_W-1:0] instrCount;
  logic                   halted;

  modport master (
    input  opcode, memReady,
    output pcWrite, pcWriteCond, branchNe, iorD, memRead, memWrite, irWrite,
           regDst, memToReg, regWrite, aluSrcA, aluSrcB, aluOp, pcSrc,
           instrRetired, instrCount, halted
  );

  modport slave (
    output opcode, memReady,
    input  pcWrite, pcWriteCond, branchNe, iorD, memRead, memWrite, irWrite,
           regDst, memToReg, regWrite, aluSrcA, aluSrcB, aluOp, pcSrc,
           instrRetired, instrCount, halted
  );
endinterface

// File: rtl/mc_control_fsm_retire_counter.sv
// Retired-instruction counter; wraps modulo 2^INSTR_CNT_W, synchronous reset.
module mc_retire_counter #(
  parameter int INSTR_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  output logic [INSTR_CNT_W-1:0] count
);
  logic [INSTR_CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (en) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;
endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control FSM: Moore decode of state, memReady-qualified fetch/load/store.
// MC_ILLEGAL_OPCODE_TRAP_EN: unknown opcodes halt instead of retiring as NOPs.
module mc_control_fsm
  import mc_pkg::*;
#(
  parameter int INSTR_CNT_W = 32
) (
  input logic              clk,
  input logic              rst,
  mc_control_fsm_if.master ctrl
);
  state_e state_q, state_d;
  logic   is_sw_q, is_sw_d;
  logic   is_bne_q, is_bne_d;
  logic   itype_and_q, itype_and_d;

  logic       pc_write, pc_write_cond, branch_ne, ior_d, mem_read, mem_write, ir_write;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, alu_op, pc_src;
  logic       reg_write, alu_src_a, instr_retired, halted;

  always_comb begin
    state_d       = state_q;
    is_sw_d       = is_sw_q;
    is_bne_d      = is_bne_q;
    itype_and_d   = itype_and_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    ior_d         = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = REGDST_RT;
    mem_to_reg    = MEMTOREG_ALU;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = ALUSRCB_B;
    alu_op        = ALUOP_ADD;
    pc_src        = PCSRC_ALU;
    instr_retired = 1'b0;
    halted        = 1'b0;

    case (state_q)
      ST_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = ALUSRCB_FOUR;
        ir_write  = ctrl.memReady;
        pc_write  = ctrl.memReady;
        if (ctrl.memReady) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        // ALU computes the branch target into ALUOut while the opcode is decoded
        alu_src_b   = ALUSRCB_IMM_SH;
        is_sw_d     = (ctrl.opcode == OP_SW);
        is_bne_d    = (ctrl.opcode == OP_BNE);
        itype_and_d = (ctrl.opcode == OP_ANDI);
        case (ctrl.opcode)
          OP_RTYPE:         state_d = ST_EXEC_R;
          OP_LW, OP_SW:     state_d = ST_MEM_ADDR;
          OP_BEQ, OP_BNE:   state_d = ST_BRANCH;
          OP_J:             state_d = ST_JUMP;
          OP_JAL:           state_d = ST_JAL;
          OP_ADDI, OP_ANDI: state_d = ST_EXEC_I;
          default: begin
`ifdef MC_ILLEGAL_OPCODE_TRAP_EN
            state_d = ST_HALT;
`else
            instr_retired = 1'b1;
            state_d       = ST_FETCH;
`endif
          end
        endcase
      end
      ST_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
        state_d   = ST_R_WB;
      end
      ST_R_WB: begin
        reg_dst       = REGDST_RD;
        reg_write     = 1'b1;
        instr_retired = 1'b1;
        state_d       = ST_FETCH;
      end
      ST_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUSRCB_IMM;
        alu_op    = itype_and_q ? ALUOP_AND : ALUOP_ADD;
        state_d   = ST_I_WB;
      end
      ST_I_WB: begin
        reg_write     = 1'b1;
        instr_retired = 1'b1;
        state_d       = ST_FETCH;
      end
      ST_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUSRCB_IMM;
        state_d   = is_sw_q ? ST_MEM_WR : ST_MEM_RD;
      end
      ST_MEM_RD: begin
        mem_read = 1'b1;
        ior_d    = 1'b1;
        if (ctrl.memReady) state_d = ST_MEM_WB;
      end
      ST_MEM_WB: begin
        mem_to_reg    = MEMTOREG_MDR;
        reg_write     = 1'b1;
        instr_retired = 1'b1;
        state_d       = ST_FETCH;
      end
      ST_MEM_WR: begin
        mem_write = 1'b1;
        ior_d     = 1'b1;
        if (ctrl.memReady) begin
          instr_retired = 1'b1;
          state_d       = ST_FETCH;
        end
      end
      ST_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_src        = PCSRC_ALUOUT;
        branch_ne     = is_bne_q;
        instr_retired = 1'b1;
        state_d       = ST_FETCH;
      end
      ST_JUMP: begin
        pc_write      = 1'b1;
        pc_src        = PCSRC_JUMP;
        instr_retired = 1'b1;
        state_d       = ST_FETCH;
      end
      ST_JAL: begin
        // PC already holds PC+4 from FETCH, so it is the link value
        pc_write      = 1'b1;
        pc_src        = PCSRC_JUMP;
        reg_write     = 1'b1;
        reg_dst       = REGDST_RA;
        mem_to_reg    = MEMTOREG_PC;
        instr_retired = 1'b1;
        state_d       = ST_FETCH;
      end
`ifdef MC_ILLEGAL_OPCODE_TRAP_EN
      ST_HALT: halted = 1'b1;
`endif
      default: state_d = ST_FETCH;
    endcase

    // Reset abandons the in-flight instruction: no write of any kind this cycle
    if (rst) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      branch_ne     = 1'b0;
      ior_d         = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_dst       = 2'b00;
      mem_to_reg    = 2'b00;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_src        = 2'b00;
      instr_retired = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FETCH;
      is_sw_q     <= 1'b0;
      is_bne_q    <= 1'b0;
      itype_and_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_sw_q     <= is_sw_d;
      is_bne_q    <= is_bne_d;
      itype_and_q <= itype_and_d;
    end
  end

  mc_retire_counter #(.INSTR_CNT_W(INSTR_CNT_W)) u_retire_counter (
    .clk   (clk),
    .rst   (rst),
    .en    (instr_retired),
    .count (ctrl.instrCount)
  );

  assign ctrl.pcWrite      = pc_write;
  assign ctrl.pcWriteCond  = pc_write_cond;
  assign ctrl.branchNe     = branch_ne;
  assign ctrl.iorD         = ior_d;
  assign ctrl.memRead      = mem_read;
  assign ctrl.memWrite     = mem_write;
  assign ctrl.irWrite      = ir_write;
  assign ctrl.regDst       = reg_dst;
  assign ctrl.memToReg     = mem_to_reg;
  assign ctrl.regWrite     = reg_write;
  assign ctrl.aluSrcA      = alu_src_a;
  assign ctrl.aluSrcB      = alu_src_b;
  assign ctrl.aluOp        = alu_op;
  assign ctrl.pcSrc        = pc_src;
  assign ctrl.instrRetired = instr_retired;
  assign ctrl.halted       = halted;
endmodule
